// File: rtl/banked_register_file_p.sv
// Banked register file with a post-reset clear sweep, same-cycle write forwarding,
// a PC alias register and signed condition flags derived from GPR writes.
module banked_register_file_p #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int BANK_WIDTH = 1,
  parameter int PC_INDEX   = 6,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  input  logic [BANK_WIDTH-1:0] active_bank,
  input  logic [ADDR_WIDTH-1:0] left_register_num,
  output logic [DATA_WIDTH-1:0] left_register_out,
  input  logic [ADDR_WIDTH-1:0] right_register_num,
  output logic [DATA_WIDTH-1:0] right_register_out,
  input  logic [ADDR_WIDTH-1:0] write_register_num,
  input  logic [DATA_WIDTH-1:0] write_register_in,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] pc_register_in,
  input  logic                  pc_write_en,
  output logic [DATA_WIDTH-1:0] pc_register_out,
  output logic [2:0]            cond_bit_out
);

  // state   | meaning
  // S_CLEAR | zeroing one storage entry per cycle, ports inert, ready low
  // S_RUN   | normal operation, terminal until the next reset

  localparam int NUM_REGS    = 2 ** ADDR_WIDTH;
  localparam int NUM_BANKS   = 2 ** BANK_WIDTH;
  localparam int NUM_ENTRIES = NUM_REGS * NUM_BANKS;
  localparam int PTR_WIDTH   = ADDR_WIDTH + BANK_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR  = ADDR_WIDTH'(PC_INDEX);
  localparam logic [PTR_WIDTH-1:0]  LAST_PTR = PTR_WIDTH'(NUM_ENTRIES - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                state;
  logic [PTR_WIDTH-1:0]  clr_ptr;
  logic [DATA_WIDTH-1:0] mem [NUM_ENTRIES];
  logic [2:0]            cond_q;
  logic                  ready_q;

  logic running;
  logic wr_zero_hit;
  logic pc_collide;
  logic gpr_we;

  assign running     = (state == S_RUN);
  assign wr_zero_hit = (ZERO_REG != 0) && (write_register_num == '0);
  // The PC write owns PC_INDEX when both strobes target it in one cycle.
  assign pc_collide  = pc_write_en && (write_register_num == PC_ADDR);
  assign gpr_we      = write_en && !wr_zero_hit && !pc_collide;

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] val;
    val = stored;
    if (!running)
      val = '0;
    else if ((ZERO_REG != 0) && (idx == '0))
      val = '0;
    else if (gpr_we && (write_register_num == idx))
      val = write_register_in;
    else if (pc_write_en && (idx == PC_ADDR))
      val = pc_register_in;
    return val;
  endfunction

  function automatic logic [2:0] flags_of(input logic [DATA_WIDTH-1:0] data);
    logic is_zero;
    is_zero = (data == '0);
    return {is_zero, !is_zero && !data[DATA_WIDTH-1], data[DATA_WIDTH-1]};
  endfunction

  logic [DATA_WIDTH-1:0] stored_left;
  logic [DATA_WIDTH-1:0] stored_right;
  logic [DATA_WIDTH-1:0] stored_pc;

  assign stored_left  = mem[{active_bank, left_register_num}];
  assign stored_right = mem[{active_bank, right_register_num}];
  assign stored_pc    = mem[{active_bank, PC_ADDR}];

  always_comb begin
    left_register_out  = read_port(left_register_num, stored_left);
    right_register_out = read_port(right_register_num, stored_right);
    pc_register_out    = read_port(PC_ADDR, stored_pc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
      cond_q  <= 3'b000;
      ready_q <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          mem[clr_ptr] <= '0;
          clr_ptr      <= clr_ptr + PTR_WIDTH'(1);
          if (clr_ptr == LAST_PTR) begin
            state   <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (gpr_we)
            mem[{active_bank, write_register_num}] <= write_register_in;
          if (pc_write_en)
            mem[{active_bank, PC_ADDR}] <= pc_register_in;
          // Suppressed zero-register writes still update the flags.
          if (write_en)
            cond_q <= flags_of(write_register_in);
        end
        default: begin
          state   <= S_CLEAR;
          clr_ptr <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready        = ready_q;
  assign cond_bit_out = cond_q;

endmodule
